// File: rtl/itch_msg_assembler_if.sv
// Ingress beat stream and parser-facing message FIFO signals of the ITCH message assembler.
// The master side feeds beats and pops messages; the slave side is the assembler.
interface itch_msg_assembler_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
);
    logic             in_valid;
    logic [63:0]      in_data;
    logic             in_last;
    logic             in_ready;
    logic             pop;
    logic             buffer_not_empty;
    logic [319:0]     ff_buffer;
    logic [CNT_W-1:0] buffer_count;
    logic [15:0]      drop_count;

    modport master (
        output in_valid, in_data, in_last, pop,
        input  in_ready, buffer_not_empty, ff_buffer, buffer_count, drop_count
    );

    modport slave (
        input  in_valid, in_data, in_last, pop,
        output in_ready, buffer_not_empty, ff_buffer, buffer_count, drop_count
    );
endinterface

// File: rtl/itch_msg_assembler.sv
// Assembles five 64-bit ingress beats into 320-bit order messages, drops malformed
// messages with a saturating counter, and queues good ones in a small FIFO.
module itch_msg_assembler #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input logic                 clk,
    input logic                 reset,
    itch_msg_assembler_if.slave bus
);
    localparam int AW = CNT_W - 1;

    typedef enum logic {ASSEMBLE, DISCARD} state_t;

    state_t           state, state_n;
    logic [2:0]       beat_cnt, beat_cnt_n;
    logic [CNT_W-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [15:0]      drop_count, drop_n;
    logic             in_ready_q, in_ready_n;
    logic [63:0]      asm_beat [4];
    logic [319:0]     mem [DEPTH];
    logic             accept, last_slot, commit, do_pop, empty, full_n;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign accept    = bus.in_valid && in_ready_q;
    assign last_slot = (beat_cnt == 3'd4);
    assign commit    = accept && (state == ASSEMBLE) && last_slot && bus.in_last;
    assign empty     = (wr_ptr == rd_ptr);
    assign do_pop    = bus.pop && !empty;
    assign wr_ptr_n  = wr_ptr + CNT_W'(commit);
    assign rd_ptr_n  = rd_ptr + CNT_W'(do_pop);
    assign full_n    = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                       (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);

    always_comb begin
        state_n    = state;
        beat_cnt_n = beat_cnt;
        drop_n     = drop_count;
        if (accept) begin
            case (state)
                ASSEMBLE: begin
                    if (!last_slot) begin
                        if (bus.in_last) begin
                            beat_cnt_n = 3'd0;
                            drop_n     = sat_inc(drop_count);
                        end else begin
                            beat_cnt_n = beat_cnt + 3'd1;
                        end
                    end else begin
                        beat_cnt_n = 3'd0;
                        if (!bus.in_last) begin
                            drop_n  = sat_inc(drop_count);
                            state_n = DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (bus.in_last) begin
                        state_n    = ASSEMBLE;
                        beat_cnt_n = 3'd0;
                    end
                end
                default: state_n = ASSEMBLE;
            endcase
        end
        // Back-pressure only while the final beat is waiting on a full FIFO.
        in_ready_n = !((state_n == ASSEMBLE) && (beat_cnt_n == 3'd4) && full_n);
    end

    // Control stage: FSM, pointers, drop counter and registered ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ASSEMBLE;
            beat_cnt   <= 3'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_count <= 16'd0;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_n;
            beat_cnt   <= beat_cnt_n;
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            drop_count <= drop_n;
            in_ready_q <= in_ready_n;
        end
    end

    // Data stage: beats 0..3 are held; beat 4 is written straight into the FIFO slot.
    always_ff @(posedge clk) begin
        if (accept && (state == ASSEMBLE) && !last_slot)
            asm_beat[beat_cnt[1:0]] <= bus.in_data;
        if (commit)
            mem[wr_ptr[AW-1:0]] <= {asm_beat[0], asm_beat[1], asm_beat[2], asm_beat[3],
                                    bus.in_data};
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.buffer_not_empty = !empty;
    assign bus.buffer_count     = wr_ptr - rd_ptr;
    assign bus.drop_count       = drop_count;
    assign bus.ff_buffer        = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: doc/itch_msg_assembler.md
Name: itch_msg_assembler

Overview:
- Upstream feed stage for the order-book parser.
- Collects 64-bit beats from the network ingress stream and assembles them into fixed 320-bit order messages.
- Queues complete messages in a small FIFO and presents the head message as ff_buffer with buffer_not_empty.
- Malformed (short or long) messages are dropped and counted; they never reach the parser.

Parameters:
DEPTH, 4, number of 320-bit message slots in the FIFO (power of two, >=2)
CNT_W, $clog2(DEPTH)+1, width of buffer_count

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  ingress beat valid
in_data  in  64  ingress beat payload
in_last  in  1  marks the final beat of a message
in_ready  out  1  beat accepted when in_valid && in_ready
pop  in  1  parser consumed head message; ignored when empty
buffer_not_empty  out  1  FIFO holds at least one message
ff_buffer  out  320  head message; all zeros when empty
buffer_count  out  CNT_W  messages currently queued
drop_count  out  16  malformed messages dropped; saturates at 16'hFFFF

Behaviour:
- Reset state (async on reset high):
  - state=ASSEMBLE, beat_cnt=0, FIFO pointers=0.
  - buffer_count=0, buffer_not_empty=0, ff_buffer=0, drop_count=0, in_ready=1.
  - Memory contents are not reset.
- Beat placement: beat k (0..4) is written to assembly register bits [319-64k : 256-64k]. Beat 0 therefore carries req_type in [319:312].
- State ASSEMBLE:
  - Beat accepted with beat_cnt<4 and in_last=0: store the beat, beat_cnt++.
  - Beat accepted with beat_cnt<4 and in_last=1 (short message): discard, beat_cnt=0, drop_count++.
  - Beat accepted with beat_cnt==4 and in_last=1: commit the assembled 320 bits to FIFO[wr_ptr], wr_ptr++, beat_cnt=0.
  - Beat accepted with beat_cnt==4 and in_last=0 (long message): discard, drop_count++, go to DISCARD.
- State DISCARD:
  - in_ready=1; all beats are dropped.
  - On the accepted beat with in_last=1: go to ASSEMBLE, beat_cnt=0.
  - No further drop_count increment for this message.
- in_ready:
  - Registered decode: 0 only when state=ASSEMBLE, beat_cnt==4 and FIFO full; otherwise 1.
  - No combinational path from pop to in_ready. A pop on a full FIFO raises in_ready on the following cycle.
- Commit latency: buffer_not_empty and ff_buffer update on the clock edge that accepts the final beat, so they are visible in the cycle after the last beat.
- Pop: read pointer advances on the edge where pop=1 and the FIFO is non-empty. The new head is visible in the next cycle.
- Simultaneous commit and pop (FIFO non-empty, not full): buffer_count unchanged, FIFO order preserved.
- Pop while empty: no effect, no underflow.
- Pointer wrap: rd_ptr and wr_ptr carry one extra bit. Full when the low bits are equal and the MSBs differ; empty when all bits are equal.
- Reset mid-message: the partial message is lost and not counted. The next 5-beat message assembles cleanly.
- drop_count saturates at 16'hFFFF.
- ff_buffer is a combinational read of mem[rd_ptr], masked to zero when empty.

Test Plan:
1. Single message: 5 beats, beat0=64'h5300_0000_0000_0000, last on beat4 -> cycle after the last beat: buffer_not_empty=1, ff_buffer[319:312]=8'h53, buffer_count=1. Pop -> next cycle buffer_not_empty=0, ff_buffer=0.
2. Full FIFO: commit 4 messages with no pop, then send 4 beats of a 5th -> in_ready=0 holding beat4. Pulse pop -> in_ready=1 next cycle, 5th commits, buffer_count=4, heads pop out in order 1..5.
3. Short message: last asserted on beat2 -> drop_count=1, buffer_count=0. Following 5-beat message commits normally.
4. Long message: 7 beats, last on beat6 -> drop_count=1, nothing committed, in_ready stays 1. Next valid message commits with correct bit placement.
5. Commit and pop in the same cycle at buffer_count=2 -> buffer_count stays 2, ff_buffer shows the former second message.
6. Reset asserted after beat3 of a message -> all outputs at reset values immediately (async). After deassert, a fresh 5-beat message commits with no stale beats and drop_count=0.
